wb_timer: RTL
=============

// Module: wb_timer
// PURPOSE
//  Wishbone classic slave on the 32-bit bus driven by the SPI-flash controller's master port.
//  It answers that master's strobe with a single-cycle ack, so it is the responder side of the bus.
//  Implements a prescaled 32-bit up-counter with compare match, overflow flag and a level interrupt.
//  Its irq output feeds the processor interrupt input.
// PARAMETERS
//  BASE    11'h000   Required value of adr_i[14:4]; other addresses are not decoded (no ack).
//  ID      32'h7131_0001   Constant returned by the ID register.
// PORTS
//  clk     in   1   Single clock; all logic on posedge.
//  reset   in   1   Synchronous, active-high reset.
//  adr_i   in   15  Word address from the master.
//  dat_i   in   32  Write data.
//  dat_o   out  32  Read data; valid while ack_o=1.
//  we_i    in   1   1=write, 0=read.
//  stb_i   in   1   Cycle request; held by the master until ack.
//  ack_o   out  1   Single-cycle acknowledge.
//  irq     out  1   Level interrupt, =|(STATUS[1:0] & CTRL[3:2]).
// BEHAVIOUR
//  Reset: ack_o=0, dat_o=0, irq=0; CTRL=0, STATUS=0, COUNT=0, COMPARE=32'hFFFF_FFFF, prescaler=0.
//  Decode: hit = stb_i & (adr_i[14:4]==BASE). Register select is adr_i[2:0]; adr_i[3]=1 is unmapped.
//  Handshake:
//   ack_o <= hit & ~ack_o.
//   Latency is 1 cycle: stb seen in cycle N gives ack in N+1.
//   stb held high after ack counts as a new access, so a continuous stb is acked every other cycle.
//   stb dropped before ack: no ack, and no side effect.
//  Write commit: on the cycle hit & we_i & ~ack_o.
//  Read capture: dat_o is loaded on the same cycle and is stable through the ack.
//  dat_o returns to 0 on the cycle after ack.
//  Register map (adr_i[2:0]):
//   0 CTRL     RW  [0] en, [1] autoreload, [2] match_ie, [3] ovf_ie, [15:8] prescale; other bits read 0.
//   1 STATUS   RW1C [0] match, [1] ovf; writing 1 clears the bit.
//   2 COUNT    RW
//   3 COMPARE  RW
//   4 ID       RO  ID; writes ignored.
//   5-7        read 0, writes ignored, still acked.
//  Prescaler:
//   The 8-bit prescaler runs only when en=1. tick=1 when prescaler==prescale, and the prescaler then clears to 0.
//   prescale=0 gives a tick every cycle. Clearing en clears the prescaler; COUNT is held.
//  Count step, on a tick:
//   If COUNT==COMPARE: set match. COUNT <= autoreload ? 0 : COUNT+1.
//   If COUNT==32'hFFFF_FFFF: COUNT wraps to 0 and ovf is set.
//  Priorities:
//   A bus write to COUNT beats a tick in the same cycle; the tick is lost.
//   A hardware set of STATUS beats a W1C in the same cycle, so the flag stays 1.
//   A COMPARE write takes effect for the next tick.
//  irq is registered and updates 1 cycle after the STATUS or CTRL change.
//  Reset asserted mid-access: ack is dropped and the in-flight access is abandoned; no retry.
// STRUCTURE
//  Shared package wb_timer_pkg holds:
//   - register offsets REG_CTRL..REG_ID;
//   - CTRL bit positions;
//   - STATUS bit positions;
//   - the ID constant.
//  Optional sub-module wb_slave_if: decode, ack generation and write/read strobes, reusable by later peripherals.
//  Counter, prescaler and flags stay in wb_timer.
// TESTING
//  1. Read ID at BASE+4, stb held -> ack exactly 1 cycle later with dat_o=32'h7131_0001.
//     stb kept high -> next ack 2 cycles later.
//  2. Write COMPARE=5, CTRL=32'h0000_0007 (en, autoreload, match_ie, prescale 0) -> COUNT runs 0..5 then 0.
//     match set on the tick at COUNT=5; irq rises 1 cycle later. Write STATUS=1 -> match clears, irq=0.
//  3. COUNT=32'hFFFF_FFFE, CTRL=32'h9 (en, ovf_ie) -> two ticks later COUNT=0, ovf=1, irq=1.
//  4. CTRL prescale=3, en=1 -> COUNT increments once every 4 clocks.
//     Clear en -> COUNT frozen and prescaler cleared.
//  5. Simultaneous cases:
//     - Write COUNT=100 on a tick cycle -> COUNT=100.
//     - W1C of match on the cycle match is set -> match stays 1.
//  6. Address and reset corner cases:
//     - adr_i[14:4]!=BASE -> never acked.
//     - Reads of BASE+3'h6 -> 0.
//     - stb dropped before ack -> no write.
//     - reset mid-access -> ack_o=0 and all registers at reset values.

Source files
------------

// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer: register offsets, CTRL/STATUS
// bit positions and the identification constant.
package wb_timer_pkg;

  // Register offsets within the 8-word window (adr_i[2:0])
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_COUNT   = 3'd2;
  localparam logic [2:0] REG_COMPARE = 3'd3;
  localparam logic [2:0] REG_ID      = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_MATCH_IE   = 2;
  localparam int CTRL_OVF_IE     = 3;
  localparam int CTRL_PRESC_LSB  = 8;
  localparam int CTRL_PRESC_MSB  = 15;

  // Only these CTRL bits are implemented; the rest read back as zero
  localparam logic [15:0] CTRL_MASK = 16'hFF0F;

  // STATUS bit positions
  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;

  // Identification constant
  localparam logic [31:0] TIMER_ID = 32'h7131_0001;

endpackage

// File: rtl/wb_slave_if.sv
// Wishbone classic slave front end: address decode, single-cycle ack,
// write strobe and registered read data. Peripheral-agnostic so later
// blocks can reuse it with their own register file behind it.
module wb_slave_if
  import wb_timer_pkg::*;
#(
  parameter logic [10:0] BASE = 11'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] adr_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] rdata,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        wr_stb,
  output logic [3:0]  reg_addr
);

  logic hit;
  logic access;

  // An access is taken on the first cycle of a hit; the ack cycle itself
  // is never an access, so a held strobe is served every other cycle.
  assign hit      = stb_i & (adr_i[14:4] == BASE);
  assign access   = hit & ~ack_o;
  assign wr_stb   = access & we_i;
  assign reg_addr = adr_i[3:0];

  // Ack generation and read-data capture; dat_o returns to 0 after the ack
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_o <= 1'b0;
      dat_o <= 32'd0;
    end else begin
      ack_o <= access;
      if (ack_o) begin
        dat_o <= 32'd0;
      end else if (access & ~we_i) begin
        dat_o <= rdata;
      end
    end
  end

endmodule

// File: rtl/wb_timer.sv
// Prescaled 32-bit up-counter with compare match, overflow flag and a
// registered level interrupt, exposed as a Wishbone classic slave.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter logic [10:0] BASE = 11'h000,
  parameter logic [31:0] ID   = TIMER_ID
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic        irq
);

  logic        wr_stb;
  logic [3:0]  reg_addr;
  logic [31:0] rdata;
  logic [3:0]  wr_sel;

  logic [15:0] ctrl_reg;
  logic [1:0]  status_reg;
  logic [1:0]  status_next;
  logic [31:0] count_reg;
  logic [31:0] count_next;
  logic [31:0] compare_reg;
  logic [7:0]  presc_reg;
  logic [7:0]  presc_next;
  logic        tick;
  logic        match_set;
  logic        ovf_set;

  wb_slave_if #(
    .BASE(BASE)
  ) u_slave_if (
    .clk      (clk),
    .reset    (reset),
    .adr_i    (adr_i),
    .stb_i    (stb_i),
    .we_i     (we_i),
    .rdata    (rdata),
    .ack_o    (ack_o),
    .dat_o    (dat_o),
    .wr_stb   (wr_stb),
    .reg_addr (reg_addr)
  );

  // One write-enable per writable register; adr_i[3]=1 selects nothing
  for (genvar gi = 0; gi < 4; gi++) begin : g_wr_sel
    assign wr_sel[gi] = wr_stb & ~reg_addr[3] & (reg_addr[2:0] == 3'(gi));
  end

  // Read mux over the current register contents
  always_comb begin
    rdata = 32'd0;
    if (!reg_addr[3]) begin
      case (reg_addr[2:0])
        REG_CTRL:    rdata = {16'd0, ctrl_reg};
        REG_STATUS:  rdata = {30'd0, status_reg};
        REG_COUNT:   rdata = count_reg;
        REG_COMPARE: rdata = compare_reg;
        REG_ID:      rdata = ID;
        default:     rdata = 32'd0;
      endcase
    end
  end

  // Prescaler: free-runs while enabled and wraps on reaching the prescale value
  always_comb begin
    tick       = 1'b0;
    presc_next = 8'd0;
    if (ctrl_reg[CTRL_EN]) begin
      if (presc_reg == ctrl_reg[CTRL_PRESC_MSB:CTRL_PRESC_LSB]) begin
        tick = 1'b1;
      end else begin
        presc_next = presc_reg + 8'd1;
      end
    end
  end

  // Count step and flag sets; a bus write to COUNT swallows a coincident tick
  always_comb begin
    count_next = count_reg;
    match_set  = 1'b0;
    ovf_set    = 1'b0;
    if (wr_sel[REG_COUNT]) begin
      count_next = dat_i;
    end else if (tick) begin
      count_next = count_reg + 32'd1;
      if (count_reg == compare_reg) begin
        match_set = 1'b1;
        if (ctrl_reg[CTRL_AUTORELOAD]) begin
          count_next = 32'd0;
        end
      end
      if (count_reg == 32'hFFFF_FFFF) begin
        ovf_set    = 1'b1;
        count_next = 32'd0;
      end
    end
  end

  // STATUS: write-one-to-clear, with hardware sets taking precedence
  always_comb begin
    status_next = status_reg;
    if (wr_sel[REG_STATUS]) begin
      status_next = status_reg & ~dat_i[1:0];
    end
    if (match_set) status_next[STAT_MATCH] = 1'b1;
    if (ovf_set)   status_next[STAT_OVF]   = 1'b1;
  end

  // Register file, counter, prescaler and interrupt state
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg    <= 16'd0;
      status_reg  <= 2'd0;
      count_reg   <= 32'd0;
      compare_reg <= 32'hFFFF_FFFF;
      presc_reg   <= 8'd0;
      irq         <= 1'b0;
    end else begin
      if (wr_sel[REG_CTRL]) begin
        ctrl_reg <= dat_i[15:0] & CTRL_MASK;
      end
      if (wr_sel[REG_COMPARE]) begin
        compare_reg <= dat_i;
      end
      status_reg <= status_next;
      count_reg  <= count_next;
      presc_reg  <= presc_next;
      irq        <= |(status_reg & ctrl_reg[CTRL_OVF_IE:CTRL_MATCH_IE]);
    end
  end

endmodule
